// File: rtl/wm1200_bus_pkg.sv
// Shared types and helpers for the WM1200 68EC020 bus responder:
// FSM states, SIZ/DSACK encodings and byte-lane decode.
package wm1200_bus_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_WAIT,
    ST_TERM,
    ST_BERR
  } bus_state_t;

  localparam logic [1:0] SIZ_LONG  = 2'b00;
  localparam logic [1:0] SIZ_BYTE  = 2'b01;
  localparam logic [1:0] SIZ_WORD  = 2'b10;
  localparam logic [1:0] SIZ_3BYTE = 2'b11;

  localparam logic [1:0] DSACK_PORT32 = 2'b00;
  localparam logic [1:0] DSACK_PORT16 = 2'b01;
  localparam logic [1:0] DSACK_PORT8  = 2'b10;
  localparam logic [1:0] DSACK_NONE   = 2'b11;

  localparam logic [2:0] FC_CPU_SPACE = 3'b111;

  // Lanes the transfer wants from a 32-bit port, starting at the addressed
  // byte and clipped at the longword boundary (bit3 = D31:24).
  function automatic logic [3:0] be_from_size(input logic [1:0] size, input logic [1:0] a10);
    logic [3:0] lanes;
    case (size)
      SIZ_BYTE:  lanes = 4'b1000;
      SIZ_WORD:  lanes = 4'b1100;
      SIZ_3BYTE: lanes = 4'b1110;
      default:   lanes = 4'b1111;
    endcase
    return lanes >> a10;
  endfunction

endpackage

// File: rtl/wm1200_bus_responder_if.sv
// 68EC020 asynchronous bus as seen between the CPU-side master and a target.
interface wm1200_bus_responder_if;
  logic [23:0] A;
  logic [2:0]  fc;
  logic        r_w;
  logic        as_n;
  logic        ds_n;
  logic [1:0]  size;
  logic [31:0] d_in;
  logic [31:0] d_out;
  logic        d_oe;
  logic [1:0]  dsack_n;
  logic        berr_n;

  modport master (
    output A, fc, r_w, as_n, ds_n, size, d_in,
    input  d_out, d_oe, dsack_n, berr_n
  );

  modport slave (
    input  A, fc, r_w, as_n, ds_n, size, d_in,
    output d_out, d_oe, dsack_n, berr_n
  );
endinterface

// File: rtl/wm1200_sync2.sv
// Two-flop synchronizer with a configurable reset value.
module wm1200_sync2 #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end
endmodule

// File: rtl/wm1200_bus_responder.sv
// 68EC020 bus target: decodes an address window, runs the access on a
// req/ack local-memory port and terminates with 32-bit DSACK or BERR.
module wm1200_bus_responder
  import wm1200_bus_pkg::*;
#(
  parameter logic [23:0] ADDR_BASE   = 24'h200000,
  parameter logic [23:0] ADDR_MASK   = 24'hE00000,
  parameter int unsigned WAIT_STATES = 0,
  parameter int unsigned TIMEOUT     = 64
) (
  input  logic                   cpuclk_a,
  input  logic                   rst,
  wm1200_bus_responder_if.slave  bus,
  output logic                   mem_req,
  output logic                   mem_we,
  output logic [21:0]            mem_addr,
  output logic [3:0]             mem_be,
  output logic [31:0]            mem_wdata,
  input  logic [31:0]            mem_rdata,
  input  logic                   mem_ack
);

  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
  localparam logic [3:0]    WS_LAST  = 4'(WAIT_STATES - 1);

  logic as_s, ds_s;

  wm1200_sync2 #(.RST_VAL(1'b1)) u_sync_as (
    .clk (cpuclk_a),
    .rst (rst),
    .d   (bus.as_n),
    .q   (as_s)
  );

  wm1200_sync2 #(.RST_VAL(1'b1)) u_sync_ds (
    .clk (cpuclk_a),
    .rst (rst),
    .d   (bus.ds_n),
    .q   (ds_s)
  );

  bus_state_t    state_q, state_d;
  logic          rw_q, rw_d;
  logic [3:0]    wcnt_q, wcnt_d;
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic [1:0]    dsack_q, dsack_d;
  logic          berr_q, berr_d;
  logic          doe_q, doe_d;
  logic [31:0]   dout_q, dout_d;
  logic          req_q, req_d;
  logic          we_q, we_d;
  logic [21:0]   addr_q, addr_d;
  logic [3:0]    be_q, be_d;
  logic [31:0]   wdata_q, wdata_d;

  logic hit;
  assign hit = (((bus.A ^ ADDR_BASE) & ADDR_MASK) == '0) && (bus.fc != FC_CPU_SPACE);

  always_ff @(posedge cpuclk_a) begin
    if (rst) begin
      state_q <= ST_IDLE;
      rw_q    <= 1'b0;
      wcnt_q  <= '0;
      tcnt_q  <= '0;
      dsack_q <= DSACK_NONE;
      berr_q  <= 1'b1;
      doe_q   <= 1'b0;
      dout_q  <= '0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      be_q    <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      rw_q    <= rw_d;
      wcnt_q  <= wcnt_d;
      tcnt_q  <= tcnt_d;
      dsack_q <= dsack_d;
      berr_q  <= berr_d;
      doe_q   <= doe_d;
      dout_q  <= dout_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
    end
  end

  // Bus outputs are registered from the current state, so DSACK/BERR
  // changes land one edge after the state that decides them.
  always_comb begin
    state_d = state_q;
    rw_d    = rw_q;
    wcnt_d  = wcnt_q;
    tcnt_d  = tcnt_q;
    dsack_d = dsack_q;
    berr_d  = berr_q;
    doe_d   = doe_q;
    dout_d  = dout_q;
    req_d   = req_q;
    we_d    = we_q;
    addr_d  = addr_q;
    be_d    = be_q;
    wdata_d = wdata_q;

    unique case (state_q)
      ST_IDLE: begin
        if (!as_s && hit) begin
          addr_d = bus.A[23:2];
          be_d   = be_from_size(bus.size, bus.A[1:0]);
          rw_d   = bus.r_w;
          // Writes wait for DS so the captured data is valid.
          if (bus.r_w || !ds_s) begin
            if (!bus.r_w) wdata_d = bus.d_in;
            req_d   = 1'b1;
            we_d    = ~bus.r_w;
            tcnt_d  = '0;
            state_d = ST_ACCESS;
          end
        end
      end
      ST_ACCESS: begin
        if (as_s) begin
          req_d   = 1'b0;
          we_d    = 1'b0;
          state_d = ST_IDLE;
        end else if (mem_ack) begin
          dout_d  = mem_rdata;
          req_d   = 1'b0;
          we_d    = 1'b0;
          wcnt_d  = '0;
          state_d = (WAIT_STATES != 0) ? ST_WAIT : ST_TERM;
        end else if (tcnt_q == TMO_LAST) begin
          req_d   = 1'b0;
          we_d    = 1'b0;
          berr_d  = 1'b0;
          state_d = ST_BERR;
        end else begin
          tcnt_d = tcnt_q + 1'b1;
        end
      end
      ST_WAIT: begin
        if (as_s) state_d = ST_IDLE;
        else if (wcnt_q == WS_LAST) state_d = ST_TERM;
        else wcnt_d = wcnt_q + 1'b1;
      end
      ST_TERM: begin
        if (as_s) begin
          dsack_d = DSACK_NONE;
          doe_d   = 1'b0;
          state_d = ST_IDLE;
        end else begin
          dsack_d = DSACK_PORT32;
          doe_d   = rw_q;
        end
      end
      ST_BERR: begin
        doe_d = 1'b0;
        if (as_s) begin
          berr_d  = 1'b1;
          state_d = ST_IDLE;
        end else begin
          berr_d = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign bus.d_out   = dout_q;
  assign bus.d_oe    = doe_q;
  assign bus.dsack_n = dsack_q;
  assign bus.berr_n  = berr_q;
  assign mem_req     = req_q;
  assign mem_we      = we_q;
  assign mem_addr    = addr_q;
  assign mem_be      = be_q;
  assign mem_wdata   = wdata_q;

endmodule

// File: doc/wm1200_bus_responder.md
# wm1200_bus_responder

Synchronous 68EC020 asynchronous-bus target: watches the address/strobe lines driven by the CPU-side bus master, decodes a configurable 24-bit address window, and terminates matching cycles with DSACK (32-bit port) or BERR. Accesses are forwarded to a simple req/ack local-memory port with big-endian byte enables. It is the slave end of the bus that `WM1200_fpga_top` masters, and it serves as an on-FPGA register/fast-RAM target and as the bench-side bus model.

## Interface
- `ADDR_BASE`, default 24'h200000: window base; compared on bits selected by `ADDR_MASK`.
- `ADDR_MASK`, default 24'hE00000: 1 = bit participates in decode.
- `WAIT_STATES`, default 0: extra cpuclk_a cycles between `mem_ack` and DSACK assertion (0..15).
- `TIMEOUT`, default 64: cycles from `mem_req` rise without `mem_ack` before BERR (≥2).

- `cpuclk_a` in 1: the single clock; all logic on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `A` in 24: CPU address.
- `fc` in 3: function code; 3'b111 (CPU space) never matches.
- `r_w` in 1: 1 = read.
- `as_n`, `ds_n` in 1: strobes, asynchronous, active low.
- `size` in 2: 68020 SIZ encoding (01 byte, 10 word, 11 3-byte, 00 long).
- `d_in` in 32: write data from bus.
- `d_out` out 32: read data to bus; `d_oe` out 1: drive enable.
- `dsack_n` out 2: active-low termination; 2'b00 = 32-bit port.
- `berr_n` out 1: active-low bus error.
- `mem_req` out 1, `mem_we` out 1, `mem_addr` out 22 (longword address A[23:2]), `mem_be` out 4 (bit3 = D31:24), `mem_wdata` out 32.
- `mem_rdata` in 32, `mem_ack` in 1: single-cycle acknowledge.

## Operation
- `as_n`, `ds_n` each pass through 2-flop synchronizers (reset value 1); FSM uses synchronized `as_s`, `ds_s` only.
- States: IDLE, ACCESS, WAIT, TERM, BERR.
- IDLE: on `as_s`=0 and `((A ^ ADDR_BASE) & ADDR_MASK)==0` and `fc`≠7: latch A, r_w, size, compute `mem_be`; reads -> ACCESS now; writes -> ACCESS once `ds_s`=0 (data valid), latching `d_in` into `mem_wdata`. No match: stay IDLE, outputs untouched (cycle belongs to another target).
- ACCESS: `mem_req`=1, `mem_we`=~r_w held until `mem_ack`. On ack: capture `mem_rdata` into `d_out`, drop `mem_req`; -> WAIT if WAIT_STATES>0 else TERM. Timeout counter reaching TIMEOUT -> BERR, `mem_req` dropped.
- WAIT: count WAIT_STATES cycles -> TERM.
- TERM: `dsack_n`=2'b00; `d_oe`=r_w. Hold until `as_s`=1, then `dsack_n`=2'b11, `d_oe`=0, -> IDLE.
- BERR: `berr_n`=0, `d_oe`=0, until `as_s`=1 -> IDLE.
- Byte enables (A[1:0] -> be): byte: 00→1000, 01→0100, 10→0010, 11→0001. Word: 00→1100, 01→0110, 10→0011, 11→0001. 3-byte: 00→1110, 01→0111, 10→0011, 11→0001. Long: 00→1111, 01→0111, 10→0011, 11→0001.
- `as_s` negating before TERM (aborted cycle): drop `mem_req`, ignore later ack, -> IDLE without DSACK.

## Timing
- Reset values: `dsack_n`=2'b11, `berr_n`=1, `d_oe`=0, `d_out`=0, `mem_req`=0, `mem_we`=0, `mem_addr`=0, `mem_be`=0, `mem_wdata`=0, FSM IDLE, counters 0. `rst` mid-cycle returns all of these on the next edge.
- `as_n` low at edge N -> `as_s` low after edge N+2 -> `mem_req` high after edge N+3 (reads).
- `mem_ack` sampled high at edge M -> `dsack_n`=00 after edge M+1+WAIT_STATES.
- `as_n` high at edge K -> `dsack_n`=11, `d_oe`=0 after edge K+3.
- `mem_ack` and timeout expiry same edge: ack wins.
- Back-to-back cycles: new cycle accepted only after returning to IDLE.

## Structure
- Package `wm1200_bus_pkg`: FSM state enum, SIZ encoding constants, `be_from_size(size, a10)` function, DSACK encodings (port 32/16/8).
- Sub-module `wm1200_sync2`: 2-flop synchronizer with reset value parameter, instantiated for `as_n`, `ds_n`.

## Test plan
- Long read at 24'h200000, `mem_rdata`=32'hDEADBEEF, ack 2 cycles after req -> `mem_be`=1111, `d_out`=DEADBEEF, `dsack_n`=00 one cycle after ack; release 3 cycles after `as_n` high.
- Byte write at 24'h200003, `d_in`=32'h000000A5 -> `mem_we`=1, `mem_be`=0001, `mem_addr`=22'h080000, `mem_wdata` captured only after `ds_n` low.
- Misaligned word read at A[1:0]=01 -> `mem_be`=0110; WAIT_STATES=3 -> DSACK 4 cycles after ack.
- No `mem_ack` with TIMEOUT=64 -> `berr_n`=0 64 cycles after `mem_req` rise, `dsack_n` stays 11, clears after `as_n` high.
- Address 24'h400000 and fc=7 at 24'h200000 -> no `mem_req`, no DSACK/BERR.
- `rst` pulse while in TERM -> next edge `dsack_n`=11, `d_oe`=0, IDLE; following cycle completes normally.
